// File: rtl/ppwm_prog_loader.sv
// Program loader for the PPWM core: host-written byte memory streamed out over valid/ready.
// Define PPWM_LOADER_CSUM_EN to append a two's-complement checksum beat to every stream.
module ppwm_prog_loader #(
  parameter int NUM_WORDS  = 16,
  parameter int WORD_W     = 8,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         btn_start,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(NUM_WORDS):0]   len,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_WORDS)-1:0] wr_addr,
  input  logic [WORD_W-1:0]            wr_data,
  output logic [WORD_W-1:0]            out_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         wr_err
);

  localparam int AW = $clog2(NUM_WORDS);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  state_t            state;
  logic [WORD_W-1:0] mem [NUM_WORDS];
  logic [AW-1:0]     ptr;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     len_clamped;
  logic [LW-1:0]     ptr_ext;
  logic              sync_q1, sync_q2;
  logic              deb_level, deb_prev;
  logic [CW-1:0]     deb_cnt;
  logic              btn_pulse, trig, xfer;

  // Button path: two-flop synchroniser, then the level must disagree for DEB_CYCLES in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync_q1  <= btn_start;
      sync_q2  <= sync_q1;
      deb_prev <= deb_level;
      if (sync_q2 != deb_level) begin
        if (deb_cnt == DEB_LAST) begin
          deb_level <= sync_q2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + CW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign btn_pulse   = deb_level & ~deb_prev;
  assign trig        = (start | btn_pulse) & ena;
  assign xfer        = out_valid & out_ready;
  assign len_clamped = (len > LW'(NUM_WORDS)) ? LW'(NUM_WORDS) : len;
  assign ptr_ext     = {1'b0, ptr};

`ifdef PPWM_LOADER_CSUM_EN
  logic [WORD_W-1:0] sum;
  logic [WORD_W-1:0] sum_next;
  assign sum_next = sum + out_data;
`else
  logic next_is_last;
  assign next_is_last = (ptr_ext + LW'(2)) == len_q;
`endif

  // Host writes are only accepted outside STREAM so the word in flight can never change.
  always_ff @(posedge clk) begin
    if (wr_en && state != STREAM) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      len_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
`ifdef PPWM_LOADER_CSUM_EN
      sum       <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (wr_en && state == STREAM) wr_err <= 1'b1;
      case (state)
        IDLE: begin
          if (trig) begin
            len_q <= len_clamped;
            ptr   <= '0;
            if (len_clamped == '0) begin
`ifdef PPWM_LOADER_CSUM_EN
              state     <= STREAM;
              out_data  <= '0;
              out_valid <= 1'b1;
              out_last  <= 1'b1;
              busy      <= 1'b1;
`else
              state <= FIN;
              done  <= 1'b1;
`endif
            end else begin
              state     <= STREAM;
              out_data  <= mem[AW'(0)];
              out_valid <= 1'b1;
              busy      <= 1'b1;
`ifdef PPWM_LOADER_CSUM_EN
              out_last  <= 1'b0;
              sum       <= '0;
`else
              out_last  <= (len_clamped == LW'(1));
`endif
            end
          end
        end
        STREAM: begin
          // A beat accepted together with abort still counts; abort only stops further beats.
          if ((xfer && out_last) || abort) begin
            state     <= FIN;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (xfer) begin
`ifdef PPWM_LOADER_CSUM_EN
            sum <= sum_next;
            if ((ptr_ext + LW'(1)) == len_q) begin
              out_data <= -sum_next;
              out_last <= 1'b1;
            end else begin
              ptr      <= ptr + AW'(1);
              out_data <= mem[ptr + AW'(1)];
            end
`else
            ptr      <= ptr + AW'(1);
            out_data <= mem[ptr + AW'(1)];
            out_last <= next_is_last;
`endif
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppwm_prog_loader.sv
// Scoreboard bench for ppwm_prog_loader: directed streams, backpressure, debounce, abort, reset.
module tb_ppwm_prog_loader;

  localparam int NW  = 16;
  localparam int WW  = 8;
  localparam int DEB = 20;
`ifdef PPWM_LOADER_CSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena, btn_start, start, abort;
  logic [4:0]    len;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [WW-1:0] wr_data;
  logic [WW-1:0] out_data;
  logic          out_valid, out_last, out_ready;
  logic          busy, done, wr_err;

  always #5 clk = ~clk;

  ppwm_prog_loader #(.NUM_WORDS(NW), .WORD_W(WW), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_start(btn_start), .start(start),
    .abort(abort), .len(len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .wr_err(wr_err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  logic [8:0]  sb [$];
  logic [7:0]  model_mem [NW];
  logic        hold = 1'b0;
  logic [8:0]  held;
  bit          pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model_mem[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pushStream(input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      sb.push_back({(EXTRA == 0) && (i == n - 1), model_mem[i]});
      s = s + model_mem[i];
    end
`ifdef PPWM_LOADER_CSUM_EN
    sb.push_back({1'b1, 8'h00 - s});
`endif
  endtask

  task automatic applyStimulus(input logic [4:0] l, input bit push_all);
    if (push_all) pushStream((l > 5'd16) ? 16 : int'(l));
    len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int k;
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    checkOutput(name, done, 1);
    tick();
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks held beats stay stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) checkOutput("hold_stable", {out_valid, out_last, out_data}, {1'b1, held});
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL beat_unexpected: got %0h expected no beat", {out_last, out_data});
        end else begin
          checkOutput("beat", {out_last, out_data}, sb.pop_front());
        end
      end
      hold = out_valid && !out_ready;
      held = {out_last, out_data};
      if (done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int x0, d0, k, seen;
    rst_n = 1'b1; ena = 1'b1; btn_start = 1'b0; start = 1'b0; abort = 1'b0;
    len = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_state", {out_valid, out_last, busy, done, wr_err, out_data}, 0);
    rst_n = 1'b1;
    tick();

    // Basic stream of four words with the core always ready
    writeWord(4'd0, 8'h11); writeWord(4'd1, 8'h22);
    writeWord(4'd2, 8'h33); writeWord(4'd3, 8'h44);
    x0 = xfer_cnt;
    applyStimulus(5'd4, 1'b1);
    for (int i = 0; i < 4 + EXTRA; i++) begin
      checkOutput("t1_busy", busy, 1);
      checkOutput("t1_valid", out_valid, 1);
      tick();
    end
    checkOutput("t1_done", {done, busy, out_valid}, 3'b100);
    tick();
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_xfers", xfer_cnt - x0, 4 + EXTRA);

    // Backpressure pattern
    x0 = xfer_cnt;
    applyStimulus(5'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b1;
    waitDone("t2_done");
    checkOutput("t2_xfers", xfer_cnt - x0, 4 + EXTRA);

    // Bouncing button, then a clean press
    len = 5'd4;
    pushStream(4);
    d0 = done_cnt;
    for (int i = 0; i < 50; i++) begin
      btn_start = ((i / 3) % 2) != 0;
      tick();
    end
    btn_start = 1'b1;
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    checkOutput("t3_latency", (k >= 22) && (k <= 24), 1);
    waitDone("t3_done");
    checkOutput("t3_one_stream", done_cnt - d0, 1);
    btn_start = 1'b0;
    repeat (30) tick();
    pushStream(4);
    btn_start = 1'b1;
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    checkOutput("t3_repress_valid", out_valid, 1);
    waitDone("t3_repress_done");
    checkOutput("t3_two_streams", done_cnt - d0, 2);
    btn_start = 1'b0;
    repeat (30) tick();

    // Abort on the third transfer of an eight-word stream
    writeWord(4'd4, 8'h55); writeWord(4'd5, 8'h66);
    writeWord(4'd6, 8'h77); writeWord(4'd7, 8'h88);
    x0 = xfer_cnt; d0 = done_cnt;
    for (int i = 0; i < 3; i++) sb.push_back({1'b0, model_mem[i]});
    applyStimulus(5'd8, 1'b0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t4_abort_fin", {out_valid, out_last, done, busy}, 4'b0010);
    tick();
    checkOutput("t4_idle", out_valid, 0);
    checkOutput("t4_done_once", done_cnt - d0, 1);
    checkOutput("t4_xfers", xfer_cnt - x0, 3);

    // Host write to the word in flight is dropped and flagged
    checkOutput("t5_wr_err_clear", wr_err, 0);
    out_ready = 1'b0;
    applyStimulus(5'd4, 1'b1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    checkOutput("t5_wr_err", wr_err, 1);
    checkOutput("t5_data_held", out_data, 8'h11);
    out_ready = 1'b1;
    waitDone("t5_done");
    checkOutput("t5_wr_err_sticky", wr_err, 1);
    d0 = done_cnt;
    applyStimulus(5'd0, 1'b1);
`ifdef PPWM_LOADER_CSUM_EN
    checkOutput("t5_len0_csum_beat", {out_valid, out_last, out_data}, 10'h300);
    waitDone("t5_len0_done");
`else
    checkOutput("t5_len0_done", {done, out_valid, busy}, 3'b100);
    tick();
`endif
    checkOutput("t5_len0_done_once", done_cnt - d0, 1);
    applyStimulus(5'd1, 1'b1);
    waitDone("t5_mem_intact_done");

    // Disabled block ignores both start sources
    ena = 1'b0;
    d0 = done_cnt; seen = 0;
    len = 5'd4; start = 1'b1; btn_start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 30) btn_start = 1'b0;
      if (busy || out_valid) seen = 1;
      tick();
    end
    checkOutput("t6_no_stream", seen, 0);
    checkOutput("t6_no_done", done_cnt - d0, 0);
    ena = 1'b1;

    // Asynchronous reset mid-stream, then a fresh stream from word 0
    out_ready = 1'b0;
    applyStimulus(5'd4, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("t7_async_rst", {out_valid, out_last, busy, done, wr_err, out_data}, 0);
    sb.delete();
    d0 = done_cnt;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("t7_no_done", done_cnt - d0, 0);
    out_ready = 1'b1;
    applyStimulus(5'd4, 1'b1);
    checkOutput("t7_restart_valid", out_valid, 1);
    waitDone("t7_done");

    checkOutput("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppwm_prog_loader.md
Name: ppwm_prog_loader

Overview:
- Sequences configuration of the PPWM core: holds a small program (up to NUM_WORDS bytes) written by a host port and streams it to the core over a valid/ready byte interface.
- A stream starts from a debounced push-button or a one-cycle start strobe.
- Sits between the board-level top (buttons, host bus) and the core's configuration input, replacing hard-wired ui_in/uio_in ties.

Parameters:
- NUM_WORDS, 16, program memory depth in bytes; power of two, 2..256.
- WORD_W, 8, width of a program word.
- DEB_CYCLES, 1000000, cycles the synchronised button must stay stable before it is accepted (10 ms at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; when low, no new stream starts.
- btn_start  input  1  raw, asynchronous, active-high push-button.
- start  input  1  synchronous one-cycle start strobe.
- abort  input  1  synchronous stream abort.
- len  input  $clog2(NUM_WORDS)+1  number of words to stream; sampled at start.
- wr_en  input  1  host write strobe.
- wr_addr  input  $clog2(NUM_WORDS)  host write address.
- wr_data  input  WORD_W  host write data.
- out_data  output  WORD_W  word presented to the core.
- out_valid  output  1  out_data is valid.
- out_last  output  1  final beat of the stream.
- out_ready  input  1  core accepts the beat.
- busy  output  1  stream in progress.
- done  output  1  one-cycle pulse when a stream completes or is aborted.
- wr_err  output  1  sticky: a host write arrived while busy.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; debounce counter 0; debounced level 0. Program memory contents are not reset.
- btn_start path:
  - Passes through a 2-FF synchroniser.
  - The debounced level updates after the synchronised value differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
  - A 0->1 transition of the debounced level produces a one-cycle internal btn_pulse.
- Trigger: trig = (start | btn_pulse) & ena. Triggers while busy are ignored.
- FSM states are IDLE, STREAM and FIN.
  - IDLE + trig:
    - len sampled into len_q (values above NUM_WORDS are clamped to NUM_WORDS).
    - If len_q == 0, go to FIN with no beats.
    - Otherwise, address pointer = 0 and go to STREAM.
  - STREAM:
    - out_valid = 1, out_data = mem[ptr], out_last = (ptr == len_q-1), busy = 1.
    - A beat transfers on out_valid & out_ready.
    - On a transfer, ptr increments; the transfer with out_last = 1 moves to FIN.
    - out_data, out_valid and out_last are registered.
    - While out_ready is low, the values are held stable; data never changes without a transfer.
    - Back-to-back transfers: one word per cycle when out_ready stays high.
  - FIN: done = 1 for exactly one cycle, busy = 0, then IDLE.
  - Latency: trigger in cycle N gives the first out_valid in cycle N+1; the last transfer in cycle M gives done in cycle M+1.
- abort:
  - In STREAM, abort forces the FSM to FIN on the next edge, with out_valid and out_last low from then on.
  - abort and a transfer in the same cycle: the transfer counts, then FIN.
  - abort in IDLE or FIN: ignored.
  - abort and trig in the same IDLE cycle: the trigger wins.
- Host writes:
  - wr_en in IDLE or FIN writes mem[wr_addr] = wr_data on that edge.
  - wr_en while in STREAM is dropped and sets wr_err. wr_err clears only on reset.
  - A write to a word that starts streaming in the same cycle: the old value is streamed.
- Reset asserted mid-stream: outputs drop to 0 immediately (asynchronous); no done pulse.

Optional Feature:
- Macro name: PPWM_LOADER_CSUM_EN.
- When defined:
  - After the last program word, one extra beat carries the two's-complement checksum of all streamed words, so the 8-bit sum of all beats is 0.
  - out_last is asserted on that checksum beat only.
  - len_q == 0 streams a single checksum beat of 0x00.
  - On abort, the checksum is not sent.
- When undefined: no checksum beat and no checksum logic; out_last is asserted on the last program word.

Test Plan:
- Write mem[0..3] = 0x11, 0x22, 0x33, 0x44, len = 4, start pulse, out_ready held 1 -> beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting one cycle after start; out_last only on 0x44; done one cycle after; busy high 4 cycles. With CSUM_EN: a fifth beat 0x56 carries out_last.
- Same program, out_ready toggled 1,0,0,1,0,1,1 -> data and valid held stable during low cycles; order preserved; exactly 4 transfers (5 with CSUM_EN).
- btn_start bounced 0/1 every 3 cycles for 50 cycles then held 1, DEB_CYCLES = 20 (bench override) -> exactly one stream starts, first out_valid 2+20+1 cycles after the final stable edge (±1); releasing and re-pressing starts a second stream.
- len = 8, abort asserted on the 3rd transfer cycle -> 3 transfers total; out_valid low next cycle; done pulses once; no checksum beat.
- wr_en during STREAM targeting the word in flight -> streamed data unchanged and wr_err = 1 until reset; len = 0 with start -> done the cycle after, no out_valid (CSUM_EN: a single 0x00 beat with out_last).
- ena = 0 with start and button press -> no stream, busy stays 0. rst_n pulled low mid-stream -> all outputs 0 asynchronously; after release the FSM is in IDLE and a new start streams from word 0.
